cache_response_queue: RTL and testbench

//  Parametrised response buffer between the data cache and the CPU pipeline.

---
 rtl/cache_response_queue.sv | 106 ++++++++++
 tb/tb_cache_response_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_response_queue.sv
// Response FIFO between the data cache and the CPU pipeline: valid/ready handshake,
// optional zero-latency bypass when empty, synchronous flush and saturating hit/miss counters.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif

module cache_response_queue #(
  parameter int DATA_WIDTH = `WORD_WIDTH,
  parameter int ADDR_WIDTH = `PHYSICAL_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  parameter int BYPASS     = 1,
  parameter int STAT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_hit,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_hit,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic [STAT_WIDTH-1:0]   hit_count,
  output logic [STAT_WIDTH-1:0]   miss_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic                  mem_hit  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic empty, full, byp, accept, pop, wr_en, rd_en;

  always_comb begin
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    byp       = BYPASS_EN && empty;
    in_ready  = ~full & ~flush;
    // reset gating keeps the bypass path from showing a head beat while in reset
    out_valid = ~reset & ~flush & (byp ? in_valid : ~empty);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_en     = accept & ~(byp & pop);
    rd_en     = pop & ~byp;
    out_hit   = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    if (out_valid) begin
      out_hit  = byp ? in_hit  : mem_hit[rd_ptr];
      out_data = byp ? in_data : mem_data[rd_ptr];
      out_addr = byp ? in_addr : mem_addr[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_hit[wr_ptr]  <= in_hit;
      mem_data[wr_ptr] <= in_data;
      mem_addr[wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !rd_en) count <= count + CNT_ONE;
      else if (rd_en && !wr_en) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (in_hit && hit_count != '1) hit_count <= hit_count + STAT_ONE;
      if (!in_hit && miss_count != '1) miss_count <= miss_count + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_cache_response_queue.sv
// Bench for cache_response_queue: a bypass instance and a registered instance with 2-bit
// counters share one stimulus stream and are each compared against a list-based model.
module tb_cache_response_queue;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 4;

  typedef struct packed {
    logic          hit;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } beat_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_hit, out_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;

  logic a_in_ready, a_out_valid, a_out_hit;
  logic [DW-1:0] a_out_data;
  logic [AW-1:0] a_out_addr;
  logic [2:0] a_count;
  logic [15:0] a_hit, a_miss;

  logic b_in_ready, b_out_valid, b_out_hit;
  logic [DW-1:0] b_out_data;
  logic [AW-1:0] b_out_addr;
  logic [2:0] b_count;
  logic [1:0] b_hit, b_miss;

  int n_total = 0;
  int n_bad = 0;

  beat_t mbuf [2][D];
  int msize [2];
  int mhit [2];
  int mmiss [2];
  int smax [2] = '{65535, 3};
  bit mbyp [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  cache_response_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .BYPASS(1), .STAT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_hit(in_hit), .in_data(in_data), .in_addr(in_addr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_hit(a_out_hit), .out_data(a_out_data),
    .out_addr(a_out_addr), .count(a_count), .hit_count(a_hit), .miss_count(a_miss)
  );

  cache_response_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .BYPASS(0), .STAT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_hit(in_hit), .in_data(in_data), .in_addr(in_addr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_hit(b_out_hit), .out_data(b_out_data),
    .out_addr(b_out_addr), .count(b_count), .hit_count(b_hit), .miss_count(b_miss)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      msize[k] = 0;
      mhit[k]  = 0;
      mmiss[k] = 0;
    end
  endtask

  // Compare both instances against the model for the current inputs, then advance the model
  // to what the coming rising edge should produce.
  task automatic model_cycle();
    for (int k = 0; k < 2; k++) begin
      bit byp_now, e_rdy, e_ov, acc, pop;
      beat_t inb, head;
      logic [63:0] act_rdy, act_ov, act_oh, act_od, act_oa, act_cnt, act_hc, act_mc;
      inb = {in_hit, in_data, in_addr};
      byp_now = mbyp[k] && (msize[k] == 0);
      e_rdy = !flush && (msize[k] < D);
      if (byp_now) begin
        e_ov = in_valid && !flush;
        head = inb;
      end else begin
        e_ov = (msize[k] != 0) && !flush;
        head = mbuf[k][0];
      end
      act_rdy = (k == 0) ? 64'(a_in_ready)  : 64'(b_in_ready);
      act_ov  = (k == 0) ? 64'(a_out_valid) : 64'(b_out_valid);
      act_oh  = (k == 0) ? 64'(a_out_hit)   : 64'(b_out_hit);
      act_od  = (k == 0) ? 64'(a_out_data)  : 64'(b_out_data);
      act_oa  = (k == 0) ? 64'(a_out_addr)  : 64'(b_out_addr);
      act_cnt = (k == 0) ? 64'(a_count)     : 64'(b_count);
      act_hc  = (k == 0) ? 64'(a_hit)       : 64'(b_hit);
      act_mc  = (k == 0) ? 64'(a_miss)      : 64'(b_miss);
      check_val($sformatf("in_ready[%0d]", k), act_rdy, 64'(e_rdy));
      check_val($sformatf("out_valid[%0d]", k), act_ov, 64'(e_ov));
      if (e_ov) begin
        check_val($sformatf("out_hit[%0d]", k), act_oh, 64'(head.hit));
        check_val($sformatf("out_data[%0d]", k), act_od, 64'(head.data));
        check_val($sformatf("out_addr[%0d]", k), act_oa, 64'(head.addr));
      end
      check_val($sformatf("count[%0d]", k), act_cnt, 64'(msize[k]));
      check_val($sformatf("hit_count[%0d]", k), act_hc, 64'(mhit[k]));
      check_val($sformatf("miss_count[%0d]", k), act_mc, 64'(mmiss[k]));

      acc = in_valid && e_rdy;
      pop = e_ov && out_ready;
      if (flush) begin
        msize[k] = 0;
      end else begin
        if (pop && !byp_now) begin
          for (int i = 0; i < D - 1; i++) mbuf[k][i] = mbuf[k][i+1];
          msize[k]--;
        end
        if (acc && !(byp_now && pop)) begin
          mbuf[k][msize[k]] = inb;
          msize[k]++;
        end
      end
      if (acc) begin
        if (in_hit) mhit[k] = (mhit[k] < smax[k]) ? mhit[k] + 1 : smax[k];
        else mmiss[k] = (mmiss[k] < smax[k]) ? mmiss[k] + 1 : smax[k];
      end
    end
  endtask

  task automatic step(input logic v, input logic h, input logic [DW-1:0] d, input logic [AW-1:0] a,
                      input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_hit = h; in_data = d; in_addr = a; out_ready = ordy; flush = fl;
    #1;
    model_cycle();
    @(posedge clk);
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_count_a", 64'(a_count), 64'd0);
    check_val("arst_count_b", 64'(b_count), 64'd0);
    check_val("arst_ovalid_a", 64'(a_out_valid), 64'd0);
    check_val("arst_ovalid_b", 64'(b_out_valid), 64'd0);
    check_val("arst_hits_a", 64'({a_hit, a_miss}), 64'd0);
    check_val("arst_hits_b", 64'({b_hit, b_miss}), 64'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp_miss [5] = '{1, 2, 3, 3, 3};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_hit = 1'b0; out_ready = 1'b0;
    in_data = '0; in_addr = '0;
    model_clear();
    #2;
    check_val("rst_ovalid_a", 64'(a_out_valid), 64'd0);
    check_val("rst_odata_b", 64'(b_out_data), 64'd0);
    check_val("rst_count_b", 64'(b_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // zero-cycle bypass on the empty queue
    step(1'b1, 1'b1, 32'hDEADBEEF, 32'h100, 1'b1, 1'b0);
    #1;
    check_val("byp_count_a", 64'(a_count), 64'd0);
    check_val("byp_hit_a", 64'(a_hit), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // fill, refuse while full, pop-only at full, then wrap the pointers
    for (int i = 1; i <= 4; i++) step(1'b1, i[0], DW'(i), AW'(32'h200 + i), 1'b0, 1'b0);
    #1;
    check_val("full_count_b", 64'(b_count), 64'd4);
    check_val("full_ready_b", 64'(b_in_ready), 64'd0);
    step(1'b1, 1'b0, 32'd5, 32'h205, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd6, 32'h206, 1'b1, 1'b0);
    #1;
    check_val("fullpop_count_b", 64'(b_count), 64'd3);
    check_val("fullpop_ready_b", 64'(b_in_ready), 64'd1);
    for (int i = 7; i <= 12; i++) step(1'b1, i[0], DW'(i), AW'(32'h200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // flush with a beat presented in the same cycle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DW'(32'h30 + i), AW'(32'h300 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h77, 32'h377, 1'b0, 1'b1);
    #1;
    check_val("flush_count_a", 64'(a_count), 64'd0);
    check_val("flush_count_b", 64'(b_count), 64'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // 2-bit miss counter saturation
    async_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, DW'(32'h50 + i), AW'(32'h500 + i), 1'b1, 1'b0);
      #1;
      check_val($sformatf("sat_miss_b%0d", i), 64'(b_miss), 64'(exp_miss[i]));
      check_val($sformatf("sat_hit_b%0d", i), 64'(b_hit), 64'd0);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DW'(32'h60 + i), AW'(32'h600 + i), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check_val("middrain_count_b", 64'(b_count), 64'd2);
    async_reset();

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) async_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0 || n > 300 && n < 340 ? 1'b0 : 1'b1) & 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
